// File: rtl/dir_ram_write_ctrl.sv
// Direction-RAM write sequencer for the Needleman-Wunsch matrix: border cells first, then row-major cell symbols.
// Optional feature macro CORNER_WRITE_EN: also writes a traceback stop marker (000) at cell (0,0) first.
module dir_ram_write_ctrl #(
    parameter int         N       = 128,
    parameter int         BitAddr = $clog2(N + 1),
    parameter int         ADDR_W  = $clog2((N + 1) * (N + 1)),
    parameter logic [2:0] UP      = 3'b010,
    parameter logic [2:0] LEFT    = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sym_valid,
    input  logic [2:0]        sym,
    output logic              sym_ready,
    output logic [BitAddr:0]  i_idx,
    output logic [BitAddr:0]  j_idx,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT_ROW = 3'd1,
        INIT_COL = 3'd2,
        FILL     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int                IW       = BitAddr + 1;
    localparam logic [IW-1:0]     K_LAST   = IW'(N);
    localparam logic [IW-1:0]     IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ZERO   = {ADDR_W{1'b0}};
    localparam logic [IW-1:0]     I_ZERO   = {IW{1'b0}};

    state_t             state_r;
    logic [IW-1:0]      k_r;
    logic [ADDR_W-1:0]  col_addr_s;
    logic [ADDR_W-1:0]  cell_addr_s;
    logic               hs_s;

    // Address arithmetic at full RAM width, plus the datapath handshake
    always_comb begin
        col_addr_s  = ADDR_W'(k_r) * STRIDE;
        cell_addr_s = (ADDR_W'(j_idx) + A_ONE) + STRIDE * (ADDR_W'(i_idx) + A_ONE);
        sym_ready   = (state_r == FILL);
        hs_s        = sym_valid & sym_ready;
    end

    // Sequencer: state, counters and the registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= I_ZERO;
            i_idx   <= I_ZERO;
            j_idx   <= I_ZERO;
            we      <= 1'b0;
            addr    <= A_ZERO;
            wdata   <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            we    <= 1'b0;
            addr  <= A_ZERO;
            wdata <= 3'b000;
            done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        we      <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= INIT_ROW;
`ifdef CORNER_WRITE_EN
                        addr    <= A_ZERO;
                        wdata   <= 3'b000;
                        k_r     <= IDX_ONE;
`else
                        addr    <= A_ONE;
                        wdata   <= LEFT;
                        k_r     <= IW'(2);
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                INIT_ROW: begin
                    we    <= 1'b1;
                    addr  <= ADDR_W'(k_r);
                    wdata <= LEFT;
                    if (k_r == K_LAST) begin
                        state_r <= INIT_COL;
                        k_r     <= IDX_ONE;
                    end else begin
                        k_r <= k_r + IDX_ONE;
                    end
                end
                INIT_COL: begin
                    we    <= 1'b1;
                    addr  <= col_addr_s;
                    wdata <= UP;
                    if (k_r == K_LAST) begin
                        state_r <= FILL;
                        k_r     <= I_ZERO;
                        i_idx   <= I_ZERO;
                        j_idx   <= I_ZERO;
                    end else begin
                        k_r <= k_r + IDX_ONE;
                    end
                end
                FILL: begin
                    if (hs_s) begin
                        we    <= 1'b1;
                        addr  <= cell_addr_s;
                        wdata <= sym;
                        // The final cell keeps its indices so they still name it during DONE
                        if (j_idx == IDX_LAST) begin
                            if (i_idx == IDX_LAST) begin
                                state_r <= DONE;
                            end else begin
                                j_idx <= I_ZERO;
                                i_idx <= i_idx + IDX_ONE;
                            end
                        end else begin
                            j_idx <= j_idx + IDX_ONE;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    i_idx   <= I_ZERO;
                    j_idx   <= I_ZERO;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    k_r     <= I_ZERO;
                    i_idx   <= I_ZERO;
                    j_idx   <= I_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dir_ram_write_ctrl.sv
// Self-checking bench for dir_ram_write_ctrl (N=4): randomized symbols/valid against a write-list model.
module tb_dir_ram_write_ctrl;

    localparam int         N      = 4;
    localparam int         ADDR_W = $clog2((N + 1) * (N + 1));
    localparam int         IW     = $clog2(N + 1) + 1;
    localparam logic [2:0] UP     = 3'b010;
    localparam logic [2:0] LEFT   = 3'b100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sym_valid;
    logic [2:0]        sym;
    logic              sym_ready;
    logic [IW-1:0]     i_idx;
    logic [IW-1:0]     j_idx;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        wdata;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    dir_ram_write_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .sym(sym),
        .sym_ready(sym_ready), .i_idx(i_idx), .j_idx(j_idx), .we(we), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym = 3'b000;
        #3;
        n_checks++;
        if ({we, addr, wdata, i_idx, j_idx, busy, done, sym_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: we=%b addr=%0d wdata=%b i=%0d j=%0d busy=%b done=%b rdy=%b, required all 0",
                     we, addr, wdata, i_idx, j_idx, busy, done, sym_ready);
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({we, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_quiet: we=%b busy=%b done=%b, required 000", we, busy, done);
            end
        end
    endtask

    // valid_pct < 0 alternates valid 1/0; abort_at >= 0 asserts rst after that many handshakes
    task automatic run_pass(input int valid_pct, input bit poke_start, input int abort_at);
        int b_addr[$];
        logic [2:0] b_data[$];
        int nb, hs, budget, ea, ei, ej;
        bit v;
        logic [2:0] s;
`ifdef CORNER_WRITE_EN
        b_addr.push_back(0); b_data.push_back(3'b000);
`endif
        for (int k = 1; k <= N; k++) begin b_addr.push_back(k); b_data.push_back(LEFT); end
        for (int k = 1; k <= N; k++) begin b_addr.push_back(k * (N + 1)); b_data.push_back(UP); end
        nb = b_addr.size();

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < nb; c++) begin
            n_checks++;
            if ({we, addr, wdata, busy, done} !== {1'b1, ADDR_W'(b_addr[c]), b_data[c], 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL border[%0d]: we=%b addr=%0d wdata=%b busy=%b done=%b, required we=1 addr=%0d wdata=%b busy=1 done=0",
                         c, we, addr, wdata, busy, done, b_addr[c], b_data[c]);
            end
            if (c < nb - 1) begin
                n_checks++;
                if (sym_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_border[%0d]: sym_ready=%b, required 0", c, sym_ready);
                end
                start = poke_start;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end

        hs = 0; budget = 0;
        while (hs < N * N && budget < 500) begin
            n_checks++;
            if ({sym_ready, busy, done} !== 3'b110) begin
                n_fail++;
                $display("FAIL fill_status: rdy=%b busy=%b done=%b, required 110", sym_ready, busy, done);
            end
            v = (valid_pct < 0) ? ((budget % 2) == 0) : (int'($urandom_range(99)) < valid_pct);
            s = 3'($urandom);
            sym_valid = v; sym = s;
            start = poke_start & ($urandom_range(2) == 0);
            @(posedge clk); #1;
            sym_valid = 1'b0; start = 1'b0;
            if (v) begin
                ea = ((hs % N) + 1) + (N + 1) * ((hs / N) + 1);
                hs++;
            end
            n_checks++;
            if (v && {we, addr, wdata} !== {1'b1, ADDR_W'(ea), s}) begin
                n_fail++;
                $display("FAIL fill_write[%0d]: we=%b addr=%0d wdata=%b, required we=1 addr=%0d wdata=%b",
                         hs - 1, we, addr, wdata, ea, s);
            end else if (!v && {we, addr, wdata} !== '0) begin
                n_fail++;
                $display("FAIL fill_idle: we=%b addr=%0d wdata=%b, required all 0", we, addr, wdata);
            end
            ei = (hs == N * N) ? N - 1 : hs / N;
            ej = (hs == N * N) ? N - 1 : hs % N;
            n_checks++;
            if ({i_idx, j_idx} !== {IW'(ei), IW'(ej)}) begin
                n_fail++;
                $display("FAIL indices: i=%0d j=%0d, required i=%0d j=%0d", i_idx, j_idx, ei, ej);
            end
            if (hs == abort_at) begin
                rst = 1'b1;
                #1;
                n_checks++;
                if ({we, addr, wdata, i_idx, j_idx, busy, done, sym_ready} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_reset: we=%b addr=%0d wdata=%b i=%0d j=%0d busy=%b done=%b rdy=%b, required all 0",
                             we, addr, wdata, i_idx, j_idx, busy, done, sym_ready);
                end
                @(negedge clk); rst = 1'b0;
                return;
            end
            budget++;
        end
        n_checks++;
        if (hs != N * N) begin
            n_fail++;
            $display("FAIL fill_timeout: handshakes=%0d, required %0d", hs, N * N);
        end

        // Last-cell write cycle: still busy, no done yet
        n_checks++;
        if ({sym_ready, busy, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL last_cycle: rdy=%b busy=%b done=%b, required 010", sym_ready, busy, done);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, we, sym_ready, i_idx, j_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), IW'(0)}) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b we=%b rdy=%b i=%0d j=%0d, required done=1 others 0",
                     done, busy, we, sym_ready, i_idx, j_idx);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, we} !== 3'b000) begin
            n_fail++;
            $display("FAIL done_single: done=%b busy=%b we=%b, required 000", done, busy, we);
        end
    endtask

    task automatic test_full_pass();
        run_pass(100, 1'b0, -1);
    endtask

    task automatic test_valid_toggle();
        run_pass(-1, 1'b0, -1);
        run_pass(40, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_pass(70, 1'b1, -1);
    endtask

    task automatic test_reset_mid_fill();
        run_pass(80, 1'b0, 2 * N + 1);
        run_pass(60, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_valid_toggle();
        test_start_ignored();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
